mfp_7sd_scan_driver: RTL and testbench
======================================

Name: mfp_7sd_scan_driver

Overview:
- Multiplexed scan driver for the 8-digit seven-segment display on the Nexys4-DDR.
- Sits directly downstream of the AHB 7SD register slave and consumes its digit-enable, 64-bit digit, and decimal-point registers.
- Time-multiplexes one digit per slot and decodes each digit byte (hex/special character or raw segments) into active-low anode and cathode pins.
- Adds per-slot ghost blanking, slot-start input capture and a frame tick.

Parameters:
N_DIG, 8, number of digits (must be a power of 2, ≥2).
SLOT_CYCLES, 12500, clock cycles per digit slot (≥4).
BLANK_CYCLES, 250, cycles at the start of each slot with all anodes off (must be < SLOT_CYCLES).

Ports:
clk  in  1  system clock (HCLK domain).
resetn  in  1  asynchronous active-low reset.
EN  in  N_DIG  per-digit enable, active high.
DIGITS  in  8*N_DIG  digit i occupies bits [8i+7:8i].
DP  in  N_DIG  per-digit decimal point, active high.
DISP_EN_OUT  out  N_DIG  anodes, active low.
DISP_SEG_OUT  out  8  cathodes, active low, order {DP,CA,CB,CC,CD,CE,CF,CG}.
FRAME_TICK  out  1  one-cycle pulse at the start of digit-0 slot.
CUR_DIGIT  out  log2(N_DIG)  index of the digit currently being scanned.

Behaviour:
- Reset (async, resetn=0):
  - slot_cnt=0, dig_idx=0, all captured registers 0.
  - DISP_EN_OUT all 1, DISP_SEG_OUT=8'hFF, FRAME_TICK=0, CUR_DIGIT=0.
  - Release is synchronous to the next clk edge.
- Slot counter: slot_cnt counts 0..SLOT_CYCLES-1, then wraps to 0.
  - On wrap, dig_idx increments modulo N_DIG.
  - N_DIG-1 wraps to 0.
- Capture: while slot_cnt==0, the driver latches cap_en=EN[dig_idx], cap_byte=DIGITS byte dig_idx, and cap_dp=DP[dig_idx] for the new dig_idx.
  - Input changes mid-slot do not affect the current slot.
  - They appear on that digit's next slot.
- Byte decode, cap_byte[7]=1: raw mode. Segments {a..g}=cap_byte[6:0], active high.
- Byte decode, cap_byte[7]=0: character mode using code=cap_byte[4:0]; bits [6:5] are ignored. {a..g} patterns:
  - Hex digits: 0:1111110 1:0110000 2:1101101 3:1111001 4:0110011 5:1011011 6:1011111 7:1110000 8:1111111 9:1111011 A:1110111 b:0011111 C:1001110 d:0111101 E:1001111 F:1000111.
  - Specials: 16 blank:0000000, 17 '-':0000001, 18 '_':0001000, 19 'H':0110111, 20 'L':0001110, 21 'P':1100111, 22 'r':0000101, 23 'o':0011101, 24 'U':0111110, 25 'n':0010101.
  - Codes 26–31 are blank.
- Output stage (registered), evaluated from the state in the cycle after capture:
  - If slot_cnt < BLANK_CYCLES, or cap_en=0: DISP_EN_OUT all 1, DISP_SEG_OUT=8'hFF.
  - Else: DISP_EN_OUT has only bit dig_idx low, and DISP_SEG_OUT = ~{cap_dp, a,b,c,d,e,f,g}.
  - The DP bit is shown in both raw and character mode.
- Latency:
  - An input change before the capture edge reaches the pins no earlier than cycle BLANK_CYCLES+1 of the slot.
  - Anodes are never low during the first BLANK_CYCLES cycles of any slot.
  - Two anodes are never low simultaneously.
- FRAME_TICK is high for exactly one cycle, registered, in the cycle after slot_cnt wraps into dig_idx=0. Period = N_DIG*SLOT_CYCLES.
- CUR_DIGIT is a registered copy of dig_idx.
- Reset mid-slot: outputs go to their reset values immediately (asynchronously), and scanning restarts at digit 0, slot_cnt 0.
- A digit that is enabled but has code 16 keeps its anode active with no segments lit, or only the DP lit if cap_dp=1.

Test Plan:
All scenarios use N_DIG=8, SLOT_CYCLES=8, BLANK_CYCLES=2.
1. Reset: hold resetn=0 with arbitrary inputs -> DISP_EN_OUT=8'hFF, DISP_SEG_OUT=8'hFF, FRAME_TICK=0. Release -> first anode low at slot-0 cycle 3. FRAME_TICK pulses every 64 cycles.
2. Hex decode: EN=8'h01, DIGITS byte0=8'h00, DP=0 -> slot 0 cycles 3–8 give DISP_EN_OUT=8'hFE, DISP_SEG_OUT=8'b1000_0001. Byte0=8'h0A -> 8'b1000_1000 on the next digit-0 slot.
3. Raw and DP: EN=8'h80, byte7=8'hFF, DP=8'h80 -> during digit-7 active window DISP_EN_OUT=8'h7F, DISP_SEG_OUT=8'h00. All other slots are 8'hFF/8'hFF.
4. Disable/blanking: EN=8'hFF, all bytes 8'h08 -> each slot has exactly 2 cycles of all-off, then one anode low. An anode check over 64 cycles never shows more than one zero bit. Codes 16 and 26 give DISP_SEG_OUT=8'hFF with the anode active.
5. Mid-slot change: change byte3 from 8'h01 to 8'h02 at slot-3 cycle 5 -> pins keep 8'b1100_1111 for the rest of slot 3. The next digit-3 slot shows 8'b1001_0010.
6. Async reset mid-scan: assert resetn=0 at digit 5, cycle 4 -> outputs go to 8'hFF immediately, with no clock edge needed. After release, CUR_DIGIT=0 and the scan restarts.

Source files
------------

// File: rtl/mfp_7sd_scan_driver.sv
// Multiplexed scan driver for the 8-digit seven-segment display: one digit per slot,
// with ghost blanking at slot start, slot-start input capture and a frame tick.
module mfp_7sd_scan_driver #(
  parameter int N_DIG        = 8,
  parameter int SLOT_CYCLES  = 12500,
  parameter int BLANK_CYCLES = 250
) (
  input  logic                     clk,
  input  logic                     resetn,
  input  logic [N_DIG-1:0]         EN,
  input  logic [8*N_DIG-1:0]       DIGITS,
  input  logic [N_DIG-1:0]         DP,
  output logic [N_DIG-1:0]         DISP_EN_OUT,
  output logic [7:0]               DISP_SEG_OUT,
  output logic                     FRAME_TICK,
  output logic [$clog2(N_DIG)-1:0] CUR_DIGIT
);

  localparam int DW = $clog2(N_DIG);
  localparam int CW = $clog2(SLOT_CYCLES);
  localparam logic [CW-1:0] SLOT_LAST = CW'(SLOT_CYCLES - 1);
  localparam logic [CW-1:0] BLANK_END = CW'(BLANK_CYCLES);

  logic [CW-1:0] slot_cnt;
  logic [DW-1:0] dig_idx;
  logic          cap_en;
  logic [7:0]    cap_byte;
  logic          cap_dp;
  logic [6:0]    seg_pat;
  logic          blank;

  // Character-mode glyphs, segment order {a,b,c,d,e,f,g}, active high.
  function automatic logic [6:0] char_seg(input logic [4:0] code);
    case (code)
      5'd0:    char_seg = 7'b1111110;
      5'd1:    char_seg = 7'b0110000;
      5'd2:    char_seg = 7'b1101101;
      5'd3:    char_seg = 7'b1111001;
      5'd4:    char_seg = 7'b0110011;
      5'd5:    char_seg = 7'b1011011;
      5'd6:    char_seg = 7'b1011111;
      5'd7:    char_seg = 7'b1110000;
      5'd8:    char_seg = 7'b1111111;
      5'd9:    char_seg = 7'b1111011;
      5'd10:   char_seg = 7'b1110111;
      5'd11:   char_seg = 7'b0011111;
      5'd12:   char_seg = 7'b1001110;
      5'd13:   char_seg = 7'b0111101;
      5'd14:   char_seg = 7'b1001111;
      5'd15:   char_seg = 7'b1000111;
      5'd17:   char_seg = 7'b0000001;
      5'd18:   char_seg = 7'b0001000;
      5'd19:   char_seg = 7'b0110111;
      5'd20:   char_seg = 7'b0001110;
      5'd21:   char_seg = 7'b1100111;
      5'd22:   char_seg = 7'b0000101;
      5'd23:   char_seg = 7'b0011101;
      5'd24:   char_seg = 7'b0111110;
      5'd25:   char_seg = 7'b0010101;
      default: char_seg = 7'b0000000;
    endcase
  endfunction

  always_comb begin
    seg_pat = cap_byte[7] ? cap_byte[6:0] : char_seg(cap_byte[4:0]);
    // Slot cycle 0 is also forced dark: the capture registers still hold the previous digit then.
    blank   = (slot_cnt == '0) || (slot_cnt < BLANK_END) || !cap_en;
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      slot_cnt     <= '0;
      dig_idx      <= '0;
      cap_en       <= 1'b0;
      cap_byte     <= 8'h00;
      cap_dp       <= 1'b0;
      DISP_EN_OUT  <= '1;
      DISP_SEG_OUT <= 8'hFF;
      FRAME_TICK   <= 1'b0;
      CUR_DIGIT    <= '0;
    end else begin
      if (slot_cnt == SLOT_LAST) begin
        slot_cnt <= '0;
        dig_idx  <= dig_idx + 1'b1;
      end else begin
        slot_cnt <= slot_cnt + 1'b1;
      end

      if (slot_cnt == '0) begin
        cap_en   <= EN[dig_idx];
        cap_byte <= DIGITS[{dig_idx, 3'b000} +: 8];
        cap_dp   <= DP[dig_idx];
      end

      if (blank) begin
        DISP_EN_OUT  <= '1;
        DISP_SEG_OUT <= 8'hFF;
      end else begin
        DISP_EN_OUT  <= ~(N_DIG'(1) << dig_idx);
        DISP_SEG_OUT <= ~{cap_dp, seg_pat};
      end

      FRAME_TICK <= (slot_cnt == '0) && (dig_idx == '0);
      CUR_DIGIT  <= dig_idx;
    end
  end

endmodule

// File: tb/tb_mfp_7sd_scan_driver.sv
// Scoreboard bench for the 7-segment scan driver: expected pin states are queued as
// each clock is issued and popped for comparison once the DUT has registered them.
module tb_mfp_7sd_scan_driver;
  localparam int N_DIG = 8, SLOT_CYCLES = 8, BLANK_CYCLES = 2;

  logic        clk = 1'b0;
  logic        resetn = 1'b0;
  logic [7:0]  en = '0;
  logic [63:0] digits = '0;
  logic [7:0]  dp = '0;
  logic [7:0]  disp_en_out;
  logic [7:0]  disp_seg_out;
  logic        frame_tick;
  logic [2:0]  cur_digit;

  mfp_7sd_scan_driver #(
    .N_DIG(N_DIG), .SLOT_CYCLES(SLOT_CYCLES), .BLANK_CYCLES(BLANK_CYCLES)
  ) dut (
    .clk(clk), .resetn(resetn), .EN(en), .DIGITS(digits), .DP(dp),
    .DISP_EN_OUT(disp_en_out), .DISP_SEG_OUT(disp_seg_out),
    .FRAME_TICK(frame_tick), .CUR_DIGIT(cur_digit)
  );

  always #5 clk = ~clk;

  int vectors = 0;
  int miscompares = 0;
  int n_edges = 0;
  logic        m_en;
  logic [7:0]  m_byte;
  logic        m_dp;
  logic [19:0] exp_q[$];
  logic [6:0]  seg_tab[32];
  localparam logic [19:0] RESET_PINS = {8'hFF, 8'hFF, 1'b0, 3'd0};

  function automatic logic [19:0] observed();
    return {disp_en_out, disp_seg_out, frame_tick, cur_digit};
  endfunction

  // Queue what the pins must show after the next edge, then issue that edge.
  task automatic clock_cycle();
    int pos = n_edges % SLOT_CYCLES;
    int d   = (n_edges / SLOT_CYCLES) % N_DIG;
    logic [7:0] e_en  = 8'hFF;
    logic [7:0] e_seg = 8'hFF;
    logic [6:0] pat;
    if (pos == 0) begin
      m_en   = en[d];
      m_byte = digits[8*d +: 8];
      m_dp   = dp[d];
    end
    if (pos >= BLANK_CYCLES && m_en) begin
      e_en  = ~(8'd1 << d);
      pat   = m_byte[7] ? m_byte[6:0] : seg_tab[m_byte[4:0]];
      e_seg = ~{m_dp, pat};
    end
    exp_q.push_back({e_en, e_seg, (pos == 0 && d == 0), 3'(d)});
    @(posedge clk); #1;
    n_edges++;
  endtask

  task automatic restart_scan();
    resetn = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    n_edges = 0;
    exp_q.delete();
    resetn = 1'b1;
  endtask

  task automatic test_reset();
    logic [19:0] exp;
    en = 8'hFF; digits = 64'h0123_4567_89AB_CDEF; dp = 8'h5A;
    resetn = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); #1;
      vectors++;
      if (observed() !== RESET_PINS) begin
        miscompares++;
        $display("FAIL reset_hold cyc%0d got %h want %h", i, observed(), RESET_PINS);
      end
    end
    en = 8'h01; digits = '0; dp = '0;
    n_edges = 0; exp_q.delete();
    resetn = 1'b1;
    for (int i = 0; i < 140; i++) begin
      clock_cycle();
      exp = exp_q.pop_front();
      vectors++;
      if (observed() !== exp) begin
        miscompares++;
        $display("FAIL reset_release cyc%0d got %h want %h", n_edges, observed(), exp);
      end
    end
  endtask

  task automatic test_hex_decode();
    logic [19:0] exp;
    restart_scan();
    en = 8'h01; digits = '0; dp = '0;
    for (int i = 0; i < 128; i++) begin
      if (i == 64) digits[7:0] = 8'h0A;
      clock_cycle();
      exp = exp_q.pop_front();
      vectors++;
      if (observed() !== exp) begin
        miscompares++;
        $display("FAIL hex_decode cyc%0d got %h want %h", n_edges, observed(), exp);
      end
    end
  endtask

  task automatic test_raw_dp();
    logic [19:0] exp;
    en = 8'h80; digits = '0; digits[63:56] = 8'hFF; dp = 8'h80;
    for (int i = 0; i < 128; i++) begin
      clock_cycle();
      exp = exp_q.pop_front();
      vectors++;
      if (observed() !== exp) begin
        miscompares++;
        $display("FAIL raw_dp cyc%0d got %h want %h", n_edges, observed(), exp);
      end
    end
  endtask

  task automatic test_blanking();
    logic [19:0] exp;
    int low_bits;
    en = 8'hFF; digits = {8{8'h08}}; dp = '0;
    for (int i = 0; i < 128; i++) begin
      if (i == 64) begin
        digits[23:16] = 8'h10;
        digits[47:40] = 8'h1A;
        dp = 8'h02;
      end
      clock_cycle();
      exp = exp_q.pop_front();
      low_bits = 0;
      for (int b = 0; b < 8; b++) if (disp_en_out[b] === 1'b0) low_bits++;
      vectors++;
      if (observed() !== exp || low_bits > 1) begin
        miscompares++;
        $display("FAIL blanking cyc%0d got %h want %h low_anodes %0d", n_edges, observed(), exp, low_bits);
      end
    end
  endtask

  task automatic test_mid_slot();
    logic [19:0] exp;
    en = 8'h08; digits = '0; digits[31:24] = 8'h01; dp = '0;
    // Align so the change lands after cycle 5 of a digit-3 slot.
    for (int i = 0; i < 200 && (n_edges % 64) != 29; i++) begin
      clock_cycle();
      exp = exp_q.pop_front();
      vectors++;
      if (observed() !== exp) begin
        miscompares++;
        $display("FAIL mid_slot_pre cyc%0d got %h want %h", n_edges, observed(), exp);
      end
    end
    digits[31:24] = 8'h02;
    for (int i = 0; i < 80; i++) begin
      clock_cycle();
      exp = exp_q.pop_front();
      vectors++;
      if (observed() !== exp) begin
        miscompares++;
        $display("FAIL mid_slot cyc%0d got %h want %h", n_edges, observed(), exp);
      end
    end
  endtask

  task automatic test_async_reset();
    logic [19:0] exp;
    en = 8'hFF; digits = 64'h1716_1514_1312_0B0A; dp = 8'h21;
    // Stop right after digit-5 slot cycle 4, with its anode lit.
    for (int i = 0; i < 200 && (n_edges % 64) != 44; i++) begin
      clock_cycle();
      exp = exp_q.pop_front();
      vectors++;
      if (observed() !== exp) begin
        miscompares++;
        $display("FAIL async_pre cyc%0d got %h want %h", n_edges, observed(), exp);
      end
    end
    #2 resetn = 1'b0;
    #1;
    vectors++;
    if (observed() !== RESET_PINS) begin
      miscompares++;
      $display("FAIL async_reset got %h want %h", observed(), RESET_PINS);
    end
    @(posedge clk); #1;
    n_edges = 0; exp_q.delete();
    resetn = 1'b1;
    for (int i = 0; i < 70; i++) begin
      clock_cycle();
      exp = exp_q.pop_front();
      vectors++;
      if (observed() !== exp) begin
        miscompares++;
        $display("FAIL async_restart cyc%0d got %h want %h", n_edges, observed(), exp);
      end
    end
  endtask

  initial begin
    seg_tab = '{7'b1111110, 7'b0110000, 7'b1101101, 7'b1111001,
                7'b0110011, 7'b1011011, 7'b1011111, 7'b1110000,
                7'b1111111, 7'b1111011, 7'b1110111, 7'b0011111,
                7'b1001110, 7'b0111101, 7'b1001111, 7'b1000111,
                7'b0000000, 7'b0000001, 7'b0001000, 7'b0110111,
                7'b0001110, 7'b1100111, 7'b0000101, 7'b0011101,
                7'b0111110, 7'b0010101, 7'b0000000, 7'b0000000,
                7'b0000000, 7'b0000000, 7'b0000000, 7'b0000000};
    #1;
    test_reset();
    test_hex_decode();
    test_raw_dp();
    test_blanking();
    test_mid_slot();
    test_async_reset();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
